// File: rtl/cpu_trace_pkg.sv
// Shared types and default widths for the CPU retirement trace buffer.
package cpu_trace_pkg;

   localparam int unsigned TRACE_XLEN  = 32;
   localparam int unsigned TRACE_DEPTH = 16;
   localparam int unsigned TRACE_CYC_W = 16;

   // Capture mode encodings on the mode input
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Width of one stored entry: pc, inst, wdata and cycle stamp
   function automatic int unsigned entry_w(input int unsigned xlen, input int unsigned cyc_w);
      return 3 * xlen + cyc_w;
   endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: one write port, one registered read port, read-before-write.
module trace_ram #(
   parameter int unsigned W     = 112,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic          rd_zero,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   // Storage array is deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register returns the pre-write contents; out-of-range reads give zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  rd_data <= '0;
      else if (rd_en && !rd_zero) rd_data <= mem[rd_addr];
      else                       rd_data <= '0;
   end

endmodule

// File: rtl/cpu_trace_buffer.sv
// On-chip retirement trace: captures retired instructions into a circular buffer.
module cpu_trace_buffer
   import cpu_trace_pkg::*;
#(
   parameter int unsigned XLEN  = TRACE_XLEN,
   parameter int unsigned DEPTH = TRACE_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH),
   parameter int unsigned CYC_W = TRACE_CYC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic             trig_en,
   input  logic [XLEN-1:0]  trig_pc,
   input  logic [AW-1:0]    post_cnt,
   input  logic             commit_valid,
   input  logic [XLEN-1:0]  commit_pc,
   input  logic [XLEN-1:0]  commit_inst,
   input  logic [XLEN-1:0]  commit_wdata,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_idx,
   output logic             rd_valid,
   output logic [XLEN-1:0]  rd_pc,
   output logic [XLEN-1:0]  rd_inst,
   output logic [XLEN-1:0]  rd_wdata,
   output logic [CYC_W-1:0] rd_cycle,
   output logic [AW:0]      count,
   output logic             armed,
   output logic             triggered,
   output logic             done
);

   localparam int unsigned EW = entry_w(XLEN, CYC_W);
   localparam int unsigned CW = AW + 1;

   state_t           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_d;
   logic [AW-1:0]    post_q, post_d;
   logic             trig_d;
   logic [CYC_W-1:0] cyc_q;
   logic             wr_en_c;
   logic [AW-1:0]    rd_addr_c;
   logic             rd_zero_c;
   logic [EW-1:0]    ram_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next state, write enable and pointer/counter updates; start overrides everything
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count;
      post_d   = post_q;
      trig_d   = triggered;
      wr_en_c  = 1'b0;
      case (state_q)
         ST_IDLE: ;
         ST_ARMED: begin
            if (commit_valid) begin
               wr_en_c = 1'b1;
               if (mode == MODE_FILL && count == CW'(DEPTH - 1)) begin
                  state_d = ST_DONE;
               end else if (mode == MODE_WRAP && trig_en && commit_pc == trig_pc) begin
                  trig_d  = 1'b1;
                  post_d  = post_cnt;
                  state_d = (post_cnt == '0) ? ST_DONE : ST_POST;
               end
            end
         end
         ST_POST: begin
            if (commit_valid) begin
               wr_en_c = 1'b1;
               post_d  = post_q - AW'(1);
               if (post_q == AW'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: ;
         default: state_d = ST_IDLE;
      endcase
      if (wr_en_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (count != CW'(DEPTH)) count_d = count + CW'(1);
      end
      if (start) begin
         state_d  = ST_ARMED;
         wr_ptr_d = '0;
         count_d  = '0;
         post_d   = '0;
         trig_d   = 1'b0;
         wr_en_c  = 1'b0;
      end
   end

   // Datapath registers, status flags and free-running cycle stamp
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         count     <= '0;
         post_q    <= '0;
         triggered <= 1'b0;
         cyc_q     <= '0;
         armed     <= 1'b0;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         count     <= count_d;
         post_q    <= post_d;
         triggered <= trig_d;
         cyc_q     <= cyc_q + CYC_W'(1);
         armed     <= (state_d == ST_ARMED) || (state_d == ST_POST);
         done      <= (state_d == ST_DONE);
         rd_valid  <= rd_en;
      end
   end

   // Read index is relative to the oldest entry; count==DEPTH truncates to an oldest of wr_ptr
   always_comb begin
      rd_addr_c = wr_ptr_q - AW'(count) + rd_idx;
      rd_zero_c = ({1'b0, rd_idx} >= count);
   end

   trace_ram #(
      .W     (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_c),
      .wr_addr (wr_ptr_q),
      .wr_data ({commit_pc, commit_inst, commit_wdata, cyc_q}),
      .rd_en   (rd_en),
      .rd_zero (rd_zero_c),
      .rd_addr (rd_addr_c),
      .rd_data (ram_q)
   );

   assign rd_pc    = ram_q[EW-1 -: XLEN];
   assign rd_inst  = ram_q[EW-1-XLEN -: XLEN];
   assign rd_wdata = ram_q[CYC_W +: XLEN];
   assign rd_cycle = ram_q[CYC_W-1:0];

endmodule
